// File: rtl/pixel_write_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_write_packer                                           |
// | Description : Packs 8-bit grayscale pixels, four per 32-bit SRAM word, and |
// |               produces the 54-bit {mask,addr,data} write command stream   |
// |               for an SramArbiter write port. One frame is written per     |
// |               start/done handshake into the buffer chosen by frame_sel.   |
// | Ports       : clock, reset      - clock, synchronous active-high reset     |
// |               start/start_ack   - frame request / one-cycle acknowledge    |
// |               done/done_ack     - frame complete (held) / clear            |
// |               frame_sel         - buffer select, sampled on start accept   |
// |               pix/pix_valid/pix_last/pix_ready - pixel input stream        |
// |               dout/valid/ready  - write command output stream              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_write_packer #(
    parameter int unsigned N_PIXEL    = 480000,
    parameter logic [17:0] BASE_ADDR0 = 18'd0,
    parameter logic [17:0] BASE_ADDR1 = 18'd131072
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        start_ack,
    output logic        done,
    input  logic        done_ack,
    input  logic        frame_sel,
    input  logic [7:0]  pix,
    input  logic        pix_valid,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic [53:0] dout,
    output logic        valid,
    input  logic        ready
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_RUN   = 2'd1;
    localparam logic [1:0]  c_ST_DRAIN = 2'd2;
    localparam logic [1:0]  c_ST_DONE  = 2'd3;
    localparam logic [18:0] c_LAST_IDX = 19'(N_PIXEL - 1);

    logic [1:0]  r_state;
    logic        r_start_ack;
    logic [17:0] r_word_addr;
    logic [18:0] r_pix_cnt;
    logic [1:0]  r_lane;
    logic [3:0]  r_mask;
    logic [31:0] r_acc;
    logic [53:0] r_dout;
    logic        r_valid;

    logic [1:0]  w_state_nxt;
    logic        w_start_ack_nxt;
    logic [17:0] w_word_addr_nxt;
    logic [18:0] w_pix_cnt_nxt;
    logic [1:0]  w_lane_nxt;
    logic [3:0]  w_mask_nxt;
    logic [31:0] w_acc_nxt;
    logic [53:0] w_dout_nxt;
    logic        w_valid_nxt;

    logic        w_pix_ready;
    logic        w_accept;
    logic        w_frame_end;
    logic [3:0]  w_mask_upd;
    logic [31:0] w_acc_upd;

    // The output register can take a new word whenever it is empty or is
    // being emptied this same cycle, which sustains one pixel per cycle.
    assign w_pix_ready = (r_state == c_ST_RUN) & (~r_valid | ready);
    assign w_accept    = pix_valid & w_pix_ready;
    // pix_last and the pixel-count limit together are a single end event.
    assign w_frame_end = pix_last | (r_pix_cnt == c_LAST_IDX);
    assign w_mask_upd  = r_mask | (4'b0001 << r_lane);

    always_comb begin
        w_acc_upd = r_acc;
        w_acc_upd[{r_lane, 3'b000} +: 8] = pix;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_start_ack_nxt = 1'b0;
        w_word_addr_nxt = r_word_addr;
        w_pix_cnt_nxt   = r_pix_cnt;
        w_lane_nxt      = r_lane;
        w_mask_nxt      = r_mask;
        w_acc_nxt       = r_acc;
        w_dout_nxt      = r_dout;
        w_valid_nxt     = r_valid;

        // Handshake empties the output register; a load below overrides.
        if (r_valid && ready) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = c_ST_RUN;
                    w_start_ack_nxt = 1'b1;
                    w_word_addr_nxt = frame_sel ? BASE_ADDR1 : BASE_ADDR0;
                    w_pix_cnt_nxt   = '0;
                    w_lane_nxt      = '0;
                    w_mask_nxt      = '0;
                    w_acc_nxt       = '0;
                end
            end
            c_ST_RUN: begin
                if (w_accept) begin
                    w_pix_cnt_nxt = r_pix_cnt + 19'd1;
                    w_lane_nxt    = r_lane + 2'd1;
                    w_mask_nxt    = w_mask_upd;
                    w_acc_nxt     = w_acc_upd;
                    if ((r_lane == 2'd3) || w_frame_end) begin
                        w_dout_nxt      = {w_mask_upd, r_word_addr, w_acc_upd};
                        w_valid_nxt     = 1'b1;
                        w_word_addr_nxt = r_word_addr + 18'd1;
                        w_lane_nxt      = '0;
                        w_mask_nxt      = '0;
                        w_acc_nxt       = '0;
                    end
                    if (w_frame_end) begin
                        w_state_nxt = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (!r_valid) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (done_ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_start_ack <= 1'b0;
            r_word_addr <= '0;
            r_pix_cnt   <= '0;
            r_lane      <= '0;
            r_mask      <= '0;
            r_acc       <= '0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_ack <= w_start_ack_nxt;
            r_word_addr <= w_word_addr_nxt;
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_lane      <= w_lane_nxt;
            r_mask      <= w_mask_nxt;
            r_acc       <= w_acc_nxt;
            r_dout      <= w_dout_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    assign start_ack = r_start_ack;
    assign done      = (r_state == c_ST_DONE);
    assign pix_ready = w_pix_ready;
    assign dout      = r_dout;
    assign valid     = r_valid;

endmodule
`default_nettype wire
